pmmu_arbiter: RTL and testbench

- Shares the single Pmmu port between two requesters: the CPU datapath (ControlMatrix address/strobe path) and a debug/loader port (UART program loader, memory inspector).
- Sits between the addr mux / rst mux / RsB outputs and the Pmmu instance.
- Drives ControlMatrix mem_busy_i so the CPU stalls while the debug port owns memory.
- Provides fixed CPU priority with a starvation guard for the debug port, and a per-access timeout.

---
 rtl/pmmu_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_pmmu_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmmu_arbiter.sv
// Shares the single Pmmu port between the CPU datapath and the debug/loader port.
// CPU has fixed priority, debug is forced in after MAX_CPU_WINS grants, accesses time out.
module pmmu_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MAX_CPU_WINS   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_WIDTH      = 5
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  cpu_rd_i,
  input  logic                  cpu_wr_i,
  input  logic [DATA_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wd_i,
  input  logic [2:0]            cpu_funct3_i,
  output logic                  cpu_busy_o,
  output logic                  cpu_done_o,
  output logic [DATA_WIDTH-1:0] cpu_rd_o,
  input  logic                  dbg_req_i,
  input  logic                  dbg_we_i,
  input  logic [DATA_WIDTH-1:0] dbg_addr_i,
  input  logic [DATA_WIDTH-1:0] dbg_wd_i,
  input  logic [2:0]            dbg_funct3_i,
  output logic                  dbg_gnt_o,
  output logic                  dbg_done_o,
  output logic [DATA_WIDTH-1:0] dbg_rd_o,
  output logic [DATA_WIDTH-1:0] pm_addr_o,
  output logic [DATA_WIDTH-1:0] pm_wd_o,
  output logic [2:0]            pm_funct3_o,
  output logic                  pm_rd_o,
  output logic                  pm_wr_o,
  input  logic [DATA_WIDTH-1:0] pm_rd_i,
  input  logic                  pm_rdy_i,
  output logic                  err_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_XFER = 2'd1,
    DBG_XFER = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] WIN_MAX  = CNT_WIDTH'(MAX_CPU_WINS);
  localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t                state_q, state_d;
  logic                  owner_dbg_q, owner_dbg_d;
  logic [CNT_WIDTH-1:0]  win_cnt_q, win_cnt_d;
  logic [CNT_WIDTH-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [DATA_WIDTH-1:0] pm_addr_q, pm_addr_d;
  logic [DATA_WIDTH-1:0] pm_wd_q, pm_wd_d;
  logic [2:0]            pm_funct3_q, pm_funct3_d;
  logic                  pm_rd_q, pm_rd_d;
  logic                  pm_wr_q, pm_wr_d;
  logic [DATA_WIDTH-1:0] cpu_rd_q, cpu_rd_d;
  logic [DATA_WIDTH-1:0] dbg_rd_q, dbg_rd_d;
  logic                  cpu_done_q, cpu_done_d;
  logic                  dbg_done_q, dbg_done_d;
  logic                  err_q, err_d;
  logic                  dbg_gnt_q, dbg_gnt_d;

  logic cpu_req;
  logic dbg_wins;

  assign cpu_req  = cpu_rd_i | cpu_wr_i;
  assign dbg_wins = dbg_req_i && (!cpu_req || (win_cnt_q == WIN_MAX));

  // Stall the CPU from its request cycle until its own completion cycle.
  assign cpu_busy_o = cpu_req && !((state_q == DONE) && !owner_dbg_q);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    owner_dbg_d = owner_dbg_q;
    win_cnt_d   = win_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    pm_addr_d   = pm_addr_q;
    pm_wd_d     = pm_wd_q;
    pm_funct3_d = pm_funct3_q;
    pm_rd_d     = pm_rd_q;
    pm_wr_d     = pm_wr_q;
    cpu_rd_d    = cpu_rd_q;
    dbg_rd_d    = dbg_rd_q;
    cpu_done_d  = 1'b0;
    dbg_done_d  = 1'b0;
    err_d       = 1'b0;
    dbg_gnt_d   = dbg_gnt_q;

    case (state_q)
      IDLE: begin
        if (dbg_wins) begin
          state_d     = DBG_XFER;
          owner_dbg_d = 1'b1;
          win_cnt_d   = '0;
          pm_addr_d   = dbg_addr_i;
          pm_wd_d     = dbg_wd_i;
          pm_funct3_d = dbg_funct3_i;
          pm_wr_d     = dbg_we_i;
          pm_rd_d     = !dbg_we_i;
          dbg_gnt_d   = 1'b1;
        end else if (cpu_req) begin
          state_d     = CPU_XFER;
          owner_dbg_d = 1'b0;
          pm_addr_d   = cpu_addr_i;
          pm_wd_d     = cpu_wd_i;
          pm_funct3_d = cpu_funct3_i;
          // Write wins when both CPU strobes are high.
          pm_wr_d     = cpu_wr_i;
          pm_rd_d     = !cpu_wr_i;
          if (!dbg_req_i) begin
            win_cnt_d = '0;
          end else if (win_cnt_q != WIN_MAX) begin
            win_cnt_d = win_cnt_q + CNT_ONE;
          end
        end
      end

      CPU_XFER, DBG_XFER: begin
        tmo_cnt_d = tmo_cnt_q + CNT_ONE;
        if (pm_rdy_i || (tmo_cnt_q == TMO_LAST)) begin
          state_d    = DONE;
          pm_rd_d    = 1'b0;
          pm_wr_d    = 1'b0;
          cpu_done_d = !owner_dbg_q;
          dbg_done_d = owner_dbg_q;
          err_d      = !pm_rdy_i;
          if (owner_dbg_q) begin
            dbg_rd_d = pm_rdy_i ? pm_rd_i : '0;
          end else begin
            cpu_rd_d = pm_rdy_i ? pm_rd_i : '0;
          end
        end
      end

      DONE: begin
        state_d   = IDLE;
        tmo_cnt_d = '0;
        dbg_gnt_d = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      owner_dbg_q <= 1'b0;
      win_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      pm_addr_q   <= '0;
      pm_wd_q     <= '0;
      pm_funct3_q <= '0;
      pm_rd_q     <= 1'b0;
      pm_wr_q     <= 1'b0;
      cpu_rd_q    <= '0;
      dbg_rd_q    <= '0;
      cpu_done_q  <= 1'b0;
      dbg_done_q  <= 1'b0;
      err_q       <= 1'b0;
      dbg_gnt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_dbg_q <= owner_dbg_d;
      win_cnt_q   <= win_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      pm_addr_q   <= pm_addr_d;
      pm_wd_q     <= pm_wd_d;
      pm_funct3_q <= pm_funct3_d;
      pm_rd_q     <= pm_rd_d;
      pm_wr_q     <= pm_wr_d;
      cpu_rd_q    <= cpu_rd_d;
      dbg_rd_q    <= dbg_rd_d;
      cpu_done_q  <= cpu_done_d;
      dbg_done_q  <= dbg_done_d;
      err_q       <= err_d;
      dbg_gnt_q   <= dbg_gnt_d;
    end
  end

  assign pm_addr_o   = pm_addr_q;
  assign pm_wd_o     = pm_wd_q;
  assign pm_funct3_o = pm_funct3_q;
  assign pm_rd_o     = pm_rd_q;
  assign pm_wr_o     = pm_wr_q;
  assign cpu_rd_o    = cpu_rd_q;
  assign dbg_rd_o    = dbg_rd_q;
  assign cpu_done_o  = cpu_done_q;
  assign dbg_done_o  = dbg_done_q;
  assign err_o       = err_q;
  assign dbg_gnt_o   = dbg_gnt_q;

endmodule

// File: tb/tb_pmmu_arbiter.sv
// Scoreboard bench for pmmu_arbiter: stimulus pushes expected Pmmu accesses and
// completions, a monitor pops and compares them as the DUT presents them.
module tb_pmmu_arbiter;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        cpu_rd_i, cpu_wr_i;
  logic [31:0] cpu_addr_i, cpu_wd_i;
  logic [2:0]  cpu_funct3_i;
  logic        cpu_busy_o, cpu_done_o;
  logic [31:0] cpu_rd_o;
  logic        dbg_req_i, dbg_we_i;
  logic [31:0] dbg_addr_i, dbg_wd_i;
  logic [2:0]  dbg_funct3_i;
  logic        dbg_gnt_o, dbg_done_o;
  logic [31:0] dbg_rd_o;
  logic [31:0] pm_addr_o, pm_wd_o;
  logic [2:0]  pm_funct3_o;
  logic        pm_rd_o, pm_wr_o;
  logic [31:0] pm_rd_i;
  logic        pm_rdy_i;
  logic        err_o;

  always #5 clk = ~clk;

  pmmu_arbiter #(
    .DATA_WIDTH(32), .MAX_CPU_WINS(4), .TIMEOUT_CYCLES(16), .CNT_WIDTH(5)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .cpu_rd_i(cpu_rd_i), .cpu_wr_i(cpu_wr_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wd_i(cpu_wd_i), .cpu_funct3_i(cpu_funct3_i),
    .cpu_busy_o(cpu_busy_o), .cpu_done_o(cpu_done_o), .cpu_rd_o(cpu_rd_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wd_i(dbg_wd_i), .dbg_funct3_i(dbg_funct3_i),
    .dbg_gnt_o(dbg_gnt_o), .dbg_done_o(dbg_done_o), .dbg_rd_o(dbg_rd_o),
    .pm_addr_o(pm_addr_o), .pm_wd_o(pm_wd_o), .pm_funct3_o(pm_funct3_o),
    .pm_rd_o(pm_rd_o), .pm_wr_o(pm_wr_o), .pm_rd_i(pm_rd_i), .pm_rdy_i(pm_rdy_i),
    .err_o(err_o)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  f3;
    logic        wr;
  } pm_exp_t;

  typedef struct packed {
    logic        dbg;
    logic [31:0] rdata;
    logic        err;
  } done_exp_t;

  pm_exp_t   pm_q[$];
  done_exp_t done_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int mem_wait = 0;
  bit mem_ok = 1'b1;
  int xfer_k = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  // Memory contents seen by the Pmmu model.
  function automatic logic [31:0] lookup(input logic [31:0] a);
    return (a == 32'h40) ? 32'h0000_0013 : {a[15:0], 16'hBEEF};
  endfunction

  task automatic push_pm(input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, input logic wr);
    pm_exp_t e;
    e.addr = a; e.wd = wd; e.f3 = f3; e.wr = wr;
    pm_q.push_back(e);
  endtask

  task automatic push_done(input logic dbg, input logic [31:0] rdata, input logic err);
    done_exp_t d;
    d.dbg = dbg; d.rdata = rdata; d.err = err;
    done_q.push_back(d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(cpu_done_o || dbg_done_o) && n < budget);
    if (!(cpu_done_o || dbg_done_o)) chk1(name, cpu_done_o | dbg_done_o, 1'b1);
  endtask

  // Pmmu model: ready after mem_wait strobe cycles, never when mem_ok is clear.
  initial begin : pmmu_model
    pm_rdy_i = 1'b0;
    pm_rd_i  = 32'hFFFF_FFFF;
    forever begin
      @(posedge clk);
      #1;
      if (pm_rd_o || pm_wr_o) begin
        pm_rdy_i = mem_ok && (xfer_k == mem_wait);
        pm_rd_i  = lookup(pm_addr_o);
        xfer_k++;
      end else begin
        pm_rdy_i = 1'b0;
        pm_rd_i  = 32'hFFFF_FFFF;
        xfer_k   = 0;
      end
    end
  end

  // Monitor: compares each new Pmmu access and each completion against the queues.
  initial begin : monitor
    pm_exp_t   e;
    done_exp_t d;
    logic      prev_stb;
    prev_stb = 1'b0;
    forever begin
      @(negedge clk);
      if (pm_rd_o && pm_wr_o) chk1("pm_strobe_exclusive", pm_wr_o, 1'b0);
      if ((pm_rd_o || pm_wr_o) && !prev_stb) begin
        if (pm_q.size() == 0) begin
          chk1("pm_unexpected_access", pm_rd_o | pm_wr_o, 1'b0);
        end else begin
          e = pm_q.pop_front();
          chk("pm_addr", pm_addr_o, e.addr);
          chk("pm_wd", pm_wd_o, e.wd);
          chk("pm_funct3", 32'(pm_funct3_o), 32'(e.f3));
          chk1("pm_wr", pm_wr_o, e.wr);
          chk1("pm_rd", pm_rd_o, !e.wr);
        end
      end
      prev_stb = pm_rd_o || pm_wr_o;
      if (cpu_done_o || dbg_done_o) begin
        if (done_q.size() == 0) begin
          chk1("unexpected_done", cpu_done_o | dbg_done_o, 1'b0);
        end else begin
          d = done_q.pop_front();
          chk1("done_dbg", dbg_done_o, d.dbg);
          chk1("done_cpu", cpu_done_o, !d.dbg);
          chk("done_rdata", d.dbg ? dbg_rd_o : cpu_rd_o, d.rdata);
          chk1("done_err", err_o, d.err);
        end
      end else if (err_o) begin
        chk1("err_without_done", err_o, 1'b0);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int stb;
    reset_i = 1'b1;
    cpu_rd_i = 1'b0; cpu_wr_i = 1'b0; cpu_addr_i = '0; cpu_wd_i = '0; cpu_funct3_i = '0;
    dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wd_i = '0; dbg_funct3_i = '0;
    tick(); tick();
    @(negedge clk);
    chk1("rst_pm_rd", pm_rd_o, 1'b0);
    chk1("rst_pm_wr", pm_wr_o, 1'b0);
    chk("rst_pm_addr", pm_addr_o, 32'h0);
    chk1("rst_busy", cpu_busy_o, 1'b0);
    chk1("rst_gnt", dbg_gnt_o, 1'b0);
    chk("rst_cpu_rd", cpu_rd_o, 32'h0);
    tick(); reset_i = 1'b0;

    // CPU read alone, zero-wait memory.
    tick();
    cpu_rd_i = 1'b1; cpu_addr_i = 32'h40; cpu_wd_i = 32'h1111_2222; cpu_funct3_i = 3'b010;
    push_pm(32'h40, 32'h1111_2222, 3'b010, 1'b0);
    push_done(1'b0, 32'h0000_0013, 1'b0);
    @(negedge clk);
    chk1("t1_busy_c1", cpu_busy_o, 1'b1);
    chk1("t1_pm_rd_c1", pm_rd_o, 1'b0);
    tick(); @(negedge clk);
    chk1("t1_busy_c2", cpu_busy_o, 1'b1);
    chk1("t1_pm_rd_c2", pm_rd_o, 1'b1);
    tick(); @(negedge clk);
    chk1("t1_busy_c3", cpu_busy_o, 1'b0);
    chk1("t1_done_c3", cpu_done_o, 1'b1);
    tick(); cpu_rd_i = 1'b0;
    @(negedge clk);
    chk1("t1_pm_rd_c4", pm_rd_o, 1'b0);

    // Debug write while idle.
    tick();
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 32'h100; dbg_wd_i = 32'hDEAD_BEEF;
    dbg_funct3_i = 3'b010;
    push_pm(32'h100, 32'hDEAD_BEEF, 3'b010, 1'b1);
    push_done(1'b1, 32'h0100_BEEF, 1'b0);
    @(negedge clk);
    chk1("t2_gnt_c1", dbg_gnt_o, 1'b0);
    tick(); @(negedge clk);
    chk1("t2_gnt_c2", dbg_gnt_o, 1'b1);
    chk1("t2_busy_c2", cpu_busy_o, 1'b0);
    tick(); @(negedge clk);
    chk1("t2_gnt_c3", dbg_gnt_o, 1'b1);
    chk1("t2_done_c3", dbg_done_o, 1'b1);
    tick(); dbg_req_i = 1'b0;
    @(negedge clk);
    chk1("t2_gnt_c4", dbg_gnt_o, 1'b0);

    // Simultaneous requests: CPU first, then debug, then a new CPU write.
    tick();
    mem_wait = 1;
    cpu_rd_i = 1'b1; cpu_addr_i = 32'h80; cpu_wd_i = 32'h0000_0033; cpu_funct3_i = 3'b100;
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h200; dbg_wd_i = 32'h0000_0044;
    dbg_funct3_i = 3'b001;
    push_pm(32'h80, 32'h0000_0033, 3'b100, 1'b0);
    push_pm(32'h200, 32'h0000_0044, 3'b001, 1'b0);
    push_pm(32'h84, 32'h5555_AAAA, 3'b000, 1'b1);
    push_done(1'b0, 32'h0080_BEEF, 1'b0);
    push_done(1'b1, 32'h0200_BEEF, 1'b0);
    push_done(1'b0, 32'h0084_BEEF, 1'b0);
    @(negedge clk);
    chk1("t3_busy_c1", cpu_busy_o, 1'b1);
    wait_done("t3_cpu_done_timeout", 40);
    chk1("t3_cpu_first", cpu_done_o, 1'b1);
    tick(); cpu_rd_i = 1'b0;
    tick();
    cpu_wr_i = 1'b1; cpu_addr_i = 32'h84; cpu_wd_i = 32'h5555_AAAA; cpu_funct3_i = 3'b000;
    @(negedge clk);
    chk1("t3_gnt_dbg", dbg_gnt_o, 1'b1);
    chk1("t3_busy_during_dbg", cpu_busy_o, 1'b1);
    wait_done("t3_dbg_done_timeout", 40);
    chk1("t3_busy_at_dbg_done", cpu_busy_o, 1'b1);
    tick(); dbg_req_i = 1'b0;
    wait_done("t3_cpu2_done_timeout", 40);
    tick(); cpu_wr_i = 1'b0;

    // Starvation guard: four CPU grants, then debug, twice over.
    tick();
    mem_wait = 0;
    cpu_rd_i = 1'b1; cpu_addr_i = 32'h400; cpu_wd_i = 32'h0; cpu_funct3_i = 3'b010;
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h300; dbg_wd_i = 32'h0;
    dbg_funct3_i = 3'b010;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        push_pm(32'h400, 32'h0, 3'b010, 1'b0);
        push_done(1'b0, 32'h0400_BEEF, 1'b0);
      end
      push_pm((r == 0) ? 32'h300 : 32'h304, 32'h0, 3'b010, 1'b0);
      push_done(1'b1, (r == 0) ? 32'h0300_BEEF : 32'h0304_BEEF, 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      wait_done("t4_done_timeout", 40);
      if (i == 4) begin
        tick(); dbg_addr_i = 32'h304;
      end
    end
    tick(); cpu_rd_i = 1'b0; dbg_req_i = 1'b0;

    // Timeout on a CPU read, then a normal read.
    tick();
    mem_ok = 1'b0;
    cpu_rd_i = 1'b1; cpu_addr_i = 32'h500; cpu_wd_i = 32'h0; cpu_funct3_i = 3'b010;
    push_pm(32'h500, 32'h0, 3'b010, 1'b0);
    push_done(1'b0, 32'h0, 1'b1);
    stb = 0;
    for (int i = 0; i < 40 && !cpu_done_o; i++) begin
      @(negedge clk);
      if (pm_rd_o) stb++;
    end
    chk1("t5_done_seen", cpu_done_o, 1'b1);
    chk1("t5_err", err_o, 1'b1);
    chk("t5_strobe_cycles", 32'(stb), 32'd16);
    tick(); cpu_rd_i = 1'b0; mem_ok = 1'b1;
    tick();
    cpu_rd_i = 1'b1; cpu_addr_i = 32'h44; cpu_funct3_i = 3'b001;
    push_pm(32'h44, 32'h0, 3'b001, 1'b0);
    push_done(1'b0, 32'h0044_BEEF, 1'b0);
    wait_done("t5_next_done_timeout", 40);
    tick(); cpu_rd_i = 1'b0;

    // Reset in the middle of a 2-wait debug read.
    tick();
    mem_wait = 2;
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h600; dbg_wd_i = 32'h0;
    dbg_funct3_i = 3'b101;
    push_pm(32'h600, 32'h0, 3'b101, 1'b0);
    tick(); @(negedge clk);
    chk1("t6_gnt_xfer", dbg_gnt_o, 1'b1);
    tick(); reset_i = 1'b1;
    @(negedge clk);
    chk1("t6_pm_rd_before_rst", pm_rd_o, 1'b1);
    tick(); dbg_req_i = 1'b0;
    @(negedge clk);
    chk1("t6_pm_rd_after_rst", pm_rd_o, 1'b0);
    chk1("t6_gnt_after_rst", dbg_gnt_o, 1'b0);
    chk1("t6_done_after_rst", dbg_done_o, 1'b0);
    chk("t6_pm_addr_after_rst", pm_addr_o, 32'h0);
    chk("t6_pm_funct3_after_rst", 32'(pm_funct3_o), 32'h0);
    chk("t6_cpu_rd_after_rst", cpu_rd_o, 32'h0);
    chk("t6_dbg_rd_after_rst", dbg_rd_o, 32'h0);
    tick(); reset_i = 1'b0;
    @(negedge clk);
    chk1("t6_no_done", dbg_done_o, 1'b0);

    // Normal service after reset.
    tick();
    mem_wait = 0;
    cpu_rd_i = 1'b1; cpu_addr_i = 32'h48; cpu_wd_i = 32'h77; cpu_funct3_i = 3'b000;
    push_pm(32'h48, 32'h77, 3'b000, 1'b0);
    push_done(1'b0, 32'h0048_BEEF, 1'b0);
    wait_done("t6_post_done_timeout", 40);
    tick(); cpu_rd_i = 1'b0;

    repeat (3) @(negedge clk);
    chk("pm_queue_left", 32'(pm_q.size()), 32'd0);
    chk("done_queue_left", 32'(done_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
